// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: memop encoding, FSM states and the
// access alignment helper used when DMEM_ARB_ALIGN_CHK_EN is defined.
package dmem_pkg;

    typedef enum logic [2:0] {
        MOP_LB  = 3'b000,
        MOP_LH  = 3'b001,
        MOP_LW  = 3'b010,
        MOP_LBU = 3'b100,
        MOP_LHU = 3'b101
    } memop_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Word needs addr[1:0]==0, half needs addr[0]==0, bytes always fine,
    // encodings outside the table are treated as illegal.
    function automatic logic is_misaligned(input logic [2:0] memop, input logic [1:0] addr_lo);
        logic bad;
        case (memop)
            MOP_LB, MOP_LBU: bad = 1'b0;
            MOP_LH, MOP_LHU: bad = addr_lo[0];
            MOP_LW:          bad = (addr_lo != 2'b00);
            default:         bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts one past last_grant and
// returns a one-hot grant for the first pending request found.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  grant
);

    logic found;
    int   idx;

    // Rotating priority scan starting after the previous winner
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_grant) + i) % NREQ;
            if (!found && req[IDX_W'(idx)]) begin
                grant[IDX_W'(idx)] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between NREQ requesters with a
// round-robin grant. One access every two cycles: handshake, ACCESS (memory
// driven), RESP (completion pulse to the owner with load data).
// Optional feature macro: DMEM_ARB_ALIGN_CHK_EN -- rejects misaligned or
// unknown-memop accesses (no write, rsp_err=1, rsp_rdata=0).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ-1:0]                req_wen,
    input  logic [NREQ-1:0][2:0]           req_memop,
    input  logic [NREQ-1:0][ADDR_W-1:0]    req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]    req_wdata,
    output logic [NREQ-1:0]                rsp_valid,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic                           rsp_err,
    output logic [2:0]                     mem_memop,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    output logic                           mem_wen,
    input  logic [DATA_W-1:0]              mem_rdata
);

    localparam int IDX_W = $clog2(NREQ);

    state_e             state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   owner_p1;
    logic               wen_p1;
    logic [2:0]         memop_p1;
    logic [ADDR_W-1:0]  addr_p1;
    logic [DATA_W-1:0]  wdata_p1;

    logic [NREQ-1:0]    grant;
    logic [IDX_W-1:0]   gnt_idx;
    logic               hs;
    logic               acc_err;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Encode the one-hot winner so its payload can be selected
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) gnt_idx = IDX_W'(i);
        end
    end

    // Ready only offered while the memory slot is free and not in reset
    assign req_ready = ((state != ACCESS) && !rst) ? grant : '0;
    assign hs        = |(req_valid & req_ready);

    // Handshake stage -> ACCESS stage: latch payload and owner, step the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NREQ - 1);
            owner_p1   <= '0;
            wen_p1     <= 1'b0;
            memop_p1   <= '0;
            addr_p1    <= '0;
            wdata_p1   <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (hs) begin
                        state      <= ACCESS;
                        last_grant <= gnt_idx;
                        owner_p1   <= gnt_idx;
                        wen_p1     <= req_wen[gnt_idx];
                        memop_p1   <= req_memop[gnt_idx];
                        addr_p1    <= req_addr[gnt_idx];
                        wdata_p1   <= req_wdata[gnt_idx];
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS:  state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_ALIGN_CHK_EN
    logic err_p2;

    assign acc_err = is_misaligned(memop_p1, addr_p1[1:0]);

    // ACCESS stage -> RESP stage: remember whether the access was rejected
    always_ff @(posedge clk) begin
        if (rst) begin
            err_p2 <= 1'b0;
        end else if (state == ACCESS) begin
            err_p2 <= acc_err;
        end
    end

    assign rsp_err = (state == RESP) && err_p2;
`else
    assign acc_err = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign mem_memop = memop_p1;
    assign mem_addr  = addr_p1;
    assign mem_wdata = wdata_p1;
    assign mem_wen   = (state == ACCESS) && wen_p1 && !acc_err;

    assign rsp_valid = (state == RESP) ? (NREQ'(1) << owner_p1) : '0;
    assign rsp_rdata = ((state == RESP) && !wen_p1 && !rsp_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: requests push expected responses at
// handshake time; a monitor pops and compares on every rsp_valid pulse.
module tb_dmem_arbiter;

    localparam int NREQ = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_wen;
    logic [NREQ-1:0][2:0] req_memop;
    logic [NREQ-1:0][31:0] req_addr;
    logic [NREQ-1:0][31:0] req_wdata;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic [2:0]           mem_memop;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic                 mem_wen;
    logic [31:0]          mem_rdata;

    dmem_arbiter #(.NREQ(NREQ), .ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_memop (req_memop),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_memop (mem_memop),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word-organised synchronous memory model
    logic [31:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          owner;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          glog[$];
    int          ntests = 0;
    int          nfail  = 0;
    int          wen_count = 0;
    int          wen_cyc   = -1;
    logic [31:0] wen_addr  = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_wen) begin
                wen_count++;
                wen_cyc  = cyc;
                wen_addr = mem_addr;
            end
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_owner", 32'(rsp_valid), 32'(1) << e.owner);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err",   32'(rsp_err), 32'(e.err));
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    endtask

    // Raise a request, wait (bounded) for acceptance, record the expectation
    task automatic issue(input int r, input bit wen, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input bit exp_err, output int hs);
        exp_t e;
        int   n;
        req_wen[r]   = wen;
        req_memop[r] = op;
        req_addr[r]  = addr;
        req_wdata[r] = wd;
        req_valid[r] = 1'b1;
        n  = 0;
        hs = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[r] && n < 40);
        if (!req_ready[r]) begin
            chk("hs_timeout", 32'(r), 32'hFFFF_FFFF);
            req_valid[r] = 1'b0;
        end else begin
            hs      = cyc;
            e.owner = r;
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.cyc   = cyc + 2;
            sbq.push_back(e);
            glog.push_back(r);
            @(posedge clk);
            #1 req_valid[r] = 1'b0;
        end
    endtask

    initial begin
        int h0, h1, h2, h3, c0, n;
        rst       = 1'b1;
        req_valid = '0;
        req_wen   = '0;
        req_memop = '0;
        req_addr  = '0;
        req_wdata = '0;
        fork
            monitor();
        join_none

        // Reset behaviour
        repeat (2) @(posedge clk);
        #1 req_valid = 2'b01;
        @(negedge clk);
        chk("ready_in_rst", 32'(req_ready), 32'h0);
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_err",   32'(rsp_err), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_mem_wen",   32'(mem_wen), 32'h0);
        chk("rst_mem_addr",  mem_addr, 32'h0);
        chk("rst_mem_memop", 32'(mem_memop), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk);
        #1;

        // Store then load by req0
        issue(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, h0);
        issue(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, h1);
        chk("ld_hs_after_st", 32'(h1), 32'(h0 + 2));

        // req1 store then load back-to-back
        c0 = wen_count;
        issue(1, 1'b1, 3'b010, 32'h20, 32'h12345678, 32'h0, 1'b0, h0);
        issue(1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 1'b0, h1);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_wen_pulses", 32'(wen_count - c0), 32'd1);
        chk("b2b_wen_cycle",  32'(wen_cyc), 32'(h0 + 1));
        chk("b2b_wen_addr",   wen_addr, 32'h20);
        chk("b2b_ld_hs",      32'(h1), 32'(h0 + 2));

        // Both requesters continuously valid: grants alternate
        glog.delete();
        fork
            begin
                issue(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, h0);
                issue(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, h1);
            end
            begin
                issue(1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 1'b0, h2);
                issue(1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 1'b0, h3);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("rr_count", 32'(glog.size()), 32'd4);
        if (glog.size() == 4) begin
            chk("rr_g0", 32'(glog[0]), 32'd0);
            chk("rr_g1", 32'(glog[1]), 32'd1);
            chk("rr_g2", 32'(glog[2]), 32'd0);
            chk("rr_g3", 32'(glog[3]), 32'd1);
        end

        // req1 waits while req0 owns the memory
        glog.delete();
        fork
            issue(0, 1'b1, 3'b010, 32'h30, 32'h0BADF00D, 32'h0, 1'b0, h0);
            begin
                @(posedge clk);
                #1 issue(1, 1'b0, 3'b010, 32'h30, 32'h0, 32'h0BADF00D, 1'b0, h1);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("wait_count", 32'(glog.size()), 32'd2);
        chk("wait_hs", 32'(h1), 32'(h0 + 2));

        // Reset during ACCESS of a load
        req_wen[0]   = 1'b0;
        req_memop[0] = 3'b010;
        req_addr[0]  = 32'h10;
        req_valid[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[0] && n < 20);
        chk("rstacc_hs", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstacc_no_rsp0", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1 req_valid = 2'b11;
        req_addr[1]  = 32'h20;
        req_wen[1]   = 1'b0;
        req_memop[1] = 3'b010;
        @(negedge clk);
        chk("rstacc_no_rsp1", 32'(rsp_valid), 32'h0);
        chk("rstacc_ready_rst", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstacc_ready_back", 32'(req_ready), 32'h1);
        req_valid = '0;
        @(posedge clk);
        #1;
        glog.delete();
        fork
            issue(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, h0);
            issue(1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 1'b0, h1);
        join
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_count", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) chk("post_rst_first", 32'(glog[0]), 32'd0);

        // Misaligned / unknown accesses
        c0 = wen_count;
`ifdef DMEM_ARB_ALIGN_CHK_EN
        issue(0, 1'b1, 3'b010, 32'h2,  32'hCAFEF00D, 32'h0, 1'b1, h0);
        issue(0, 1'b1, 3'b011, 32'h40, 32'h55AA55AA, 32'h0, 1'b1, h1);
        issue(0, 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, h2);
        issue(0, 1'b0, 3'b010, 32'h0,  32'h0, 32'h0, 1'b0, h3);
        repeat (3) @(posedge clk);
        #1;
        chk("align_no_wen", 32'(wen_count - c0), 32'd0);
`else
        issue(0, 1'b1, 3'b010, 32'h2,  32'hCAFEF00D, 32'h0, 1'b0, h0);
        repeat (3) @(posedge clk);
        #1;
        chk("noalign_wen_addr", wen_addr, 32'h2);
        issue(0, 1'b1, 3'b011, 32'h40, 32'h55AA55AA, 32'h0, 1'b0, h1);
        issue(0, 1'b0, 3'b001, 32'h11, 32'h0, 32'hDEADBEEF, 1'b0, h2);
        issue(0, 1'b0, 3'b010, 32'h0,  32'h0, 32'hCAFEF00D, 1'b0, h3);
        repeat (3) @(posedge clk);
        #1;
        chk("noalign_wen", 32'(wen_count - c0), 32'd2);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
